pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates operand-forwarding selects for E, plus load-use stalls and branch flushes for the pipeline registers.
- Freezes the pipeline while the multi-cycle data memory is busy.
- Holds one pending branch redirect across a memory freeze.
- Provides a memory-wait watchdog and performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_fwd.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result-source code and the sequencing FSM states.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding select for one E-stage source register.
// M beats W because it holds the younger result; x0 is never forwarded.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] rd_m,
    input  logic       reg_wr_m,
    input  logic [4:0] rd_w,
    input  logic       reg_wr_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_wr_m && (rd_m != 5'd0) && (rd_m == src)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_wr_w && (rd_w != 5'd0) && (rd_w == src)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// load-use stalls, branch flushes, memory freeze with watchdog, perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             reg_wr_e,
    input  logic [1:0]       res_src_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_wr_m,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    input  logic [4:0]       rd_w,
    input  logic             reg_wr_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             redirect,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    hz_state_e         state, state_n;
    logic              pend, pend_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;

    logic       mem_busy;
    logic       load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       stall_f_c, stall_d_c, stall_e_c, stall_m_c;
    logic       flush_d_c, flush_e_c, flush_w_c, redirect_c;
    logic       lu_inc, mw_inc, fl_inc;

    hazard_fwd_unit u_fwd_a (
        .src     (rs1_e),
        .rd_m    (rd_m),
        .reg_wr_m(reg_wr_m),
        .rd_w    (rd_w),
        .reg_wr_w(reg_wr_w),
        .fwd_sel (fwd_a_raw)
    );

    hazard_fwd_unit u_fwd_b (
        .src     (rs2_e),
        .rd_m    (rd_m),
        .reg_wr_m(reg_wr_m),
        .rd_w    (rd_w),
        .reg_wr_w(reg_wr_w),
        .fwd_sel (fwd_b_raw)
    );

    assign mem_busy = mem_req_m & ~mem_ready;
    assign load_use = (res_src_e == RES_SRC_LOAD) && reg_wr_e && (rd_e != 5'd0)
                      && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pend     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        pend_n     = pend;
        wait_cnt_n = wait_cnt;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        stall_m_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        flush_w_c  = 1'b0;
        redirect_c = 1'b0;
        lu_inc     = 1'b0;
        mw_inc     = 1'b0;
        fl_inc     = 1'b0;

        case (state)
            ST_ERR: begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                stall_m_c = 1'b1;
                flush_w_c = 1'b1;
            end
            default: begin
                if (mem_busy) begin
                    // Freeze: a branch resolved now is remembered, not applied.
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    stall_m_c = 1'b1;
                    flush_w_c = 1'b1;
                    mw_inc    = 1'b1;
                    if (pc_src_e) begin
                        pend_n = 1'b1;
                    end
                    if (state == ST_RUN) begin
                        wait_cnt_n = WAIT_ONE;
                        state_n    = ST_MEM_WAIT;
                    end else begin
                        wait_cnt_n = wait_cnt + WAIT_ONE;
                        state_n    = (wait_cnt_n >= WAIT_LIMIT) ? ST_ERR : ST_MEM_WAIT;
                    end
                end else begin
                    state_n = ST_RUN;
                    pend_n  = 1'b0;
                    if (pc_src_e || pend) begin
                        redirect_c = 1'b1;
                        flush_d_c  = 1'b1;
                        flush_e_c  = 1'b1;
                        fl_inc     = 1'b1;
                    end else if (load_use) begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        flush_e_c = 1'b1;
                        lu_inc    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= '0;
            mem_wait_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (lu_inc && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
            if (mw_inc && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + CNT_ONE;
            if (fl_inc && (flush_cnt != '1))    flush_cnt    <= flush_cnt + CNT_ONE;
        end
    end

    // While reset is held the pipeline registers are flushed and nothing stalls.
    assign fwd_a_e  = rst_n ? fwd_a_raw : FWD_RF;
    assign fwd_b_e  = rst_n ? fwd_b_raw : FWD_RF;
    assign stall_f  = rst_n & stall_f_c;
    assign stall_d  = rst_n & stall_d_c;
    assign stall_e  = rst_n & stall_e_c;
    assign stall_m  = rst_n & stall_m_c;
    assign flush_d  = ~rst_n | flush_d_c;
    assign flush_e  = ~rst_n | flush_e_c;
    assign flush_w  = ~rst_n | flush_w_c;
    assign redirect = rst_n & redirect_c;
    assign mem_err  = (state == ST_ERR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model pushes expected
// outputs per cycle, popped and compared mid-cycle; directed checks follow.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 64;
    localparam int EXP_W   = 13 + 96;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       reg_wr_e;
        logic [1:0] res_src_e;
        logic       pc_src_e;
        logic [4:0] rd_m;
        logic       reg_wr_m, mem_req_m, mem_ready;
        logic [4:0] rd_w;
        logic       reg_wr_w;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        reg_wr_e, pc_src_e, reg_wr_m, mem_req_m, mem_ready, reg_wr_w;
    logic [1:0]  res_src_e;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w, redirect, mem_err;
    logic [31:0] lu_stall_cnt, mem_wait_cnt, flush_cnt;
    logic [12:0] obs;

    stim_t s;
    logic [EXP_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // model state: 0 run, 1 mem wait, 2 error
    int          m_state, m_state_n, m_wait, m_wait_n;
    logic        m_pend, m_pend_n;
    logic [31:0] m_lu, m_lu_n, m_mw, m_mw_n, m_fl, m_fl_n;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_wr_e(reg_wr_e), .res_src_e(res_src_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_wr_m(reg_wr_m), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .rd_w(rd_w), .reg_wr_w(reg_wr_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .redirect(redirect), .mem_err(mem_err),
        .lu_stall_cnt(lu_stall_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
    );

    assign obs = {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e, flush_w, redirect, mem_err};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (s.reg_wr_m && s.rd_m != 0 && s.rd_m == src) return 2'b10;
        if (s.reg_wr_w && s.rd_w != 0 && s.rd_w == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_pend = 1'b0; m_lu = '0; m_mw = '0; m_fl = '0;
        m_state_n = 0; m_wait_n = 0; m_pend_n = 1'b0; m_lu_n = '0; m_mw_n = '0; m_fl_n = '0;
    endtask

    task automatic model_eval(output logic [12:0] e);
        logic [3:0] stalls;
        logic fd, fe, fw, rdr, busy, lu;
        stalls = 4'b0; fd = 0; fe = 0; fw = 0; rdr = 0;
        m_state_n = m_state; m_wait_n = m_wait; m_pend_n = m_pend;
        m_lu_n = m_lu; m_mw_n = m_mw; m_fl_n = m_fl;
        busy = s.mem_req_m && !s.mem_ready;
        lu = (s.res_src_e == 2'b01) && s.reg_wr_e && (s.rd_e != 0)
             && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
        if (m_state == 2) begin
            stalls = 4'b1111; fw = 1;
        end else if (busy) begin
            stalls = 4'b1111; fw = 1;
            if (s.pc_src_e) m_pend_n = 1'b1;
            if (m_mw != 32'hffff_ffff) m_mw_n = m_mw + 1;
            m_wait_n  = (m_state == 0) ? 1 : m_wait + 1;
            m_state_n = (m_state == 1 && m_wait_n >= TIMEOUT) ? 2 : 1;
        end else begin
            m_state_n = 0; m_pend_n = 1'b0;
            if (s.pc_src_e || m_pend) begin
                rdr = 1; fd = 1; fe = 1;
                if (m_fl != 32'hffff_ffff) m_fl_n = m_fl + 1;
            end else if (lu) begin
                stalls = 4'b1100; fe = 1;
                if (m_lu != 32'hffff_ffff) m_lu_n = m_lu + 1;
            end
        end
        e = {fwd_model(s.rs1_e), fwd_model(s.rs2_e), stalls, fd, fe, fw, rdr, m_state == 2};
    endtask

    // One pipeline cycle: drive the staged stimulus, push expectation, compare.
    task automatic step();
        logic [12:0] e;
        logic [EXP_W-1:0] x;
        @(negedge clk);
        m_state = m_state_n; m_wait = m_wait_n; m_pend = m_pend_n;
        m_lu = m_lu_n; m_mw = m_mw_n; m_fl = m_fl_n;
        rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
        rd_e = s.rd_e; reg_wr_e = s.reg_wr_e; res_src_e = s.res_src_e;
        pc_src_e = s.pc_src_e; rd_m = s.rd_m; reg_wr_m = s.reg_wr_m;
        mem_req_m = s.mem_req_m; mem_ready = s.mem_ready;
        rd_w = s.rd_w; reg_wr_w = s.reg_wr_w;
        model_eval(e);
        exp_q.push_back({e, m_lu, m_mw, m_fl});
        #1;
        x = exp_q.pop_front();
        check_eq("outs", {19'b0, obs}, {19'b0, x[EXP_W-1 -: 13]});
        check_eq("lu_cnt", lu_stall_cnt, x[95:64]);
        check_eq("mw_cnt", mem_wait_cnt, x[63:32]);
        check_eq("fl_cnt", flush_cnt, x[31:0]);
    endtask

    initial begin
        s = '0;
        model_reset();
        rst_n = 1'b0;
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; reg_wr_e = 0;
        res_src_e = 0; pc_src_e = 0; rd_m = 0; reg_wr_m = 0; mem_req_m = 0;
        mem_ready = 0; rd_w = 0; reg_wr_w = 0;
        #3;
        check_eq("rst_outs", {19'b0, obs}, {19'b0, 4'b0, 4'b0, 3'b111, 2'b00});
        check_eq("rst_lu", lu_stall_cnt, 32'd0);
        #9 rst_n = 1'b1;

        // forwarding
        s = '0; s.rd_m = 5; s.reg_wr_m = 1; s.rs1_e = 5; step();
        check_eq("fwd_m", {30'b0, fwd_a_e}, 32'b10);
        s = '0; s.rd_w = 5; s.reg_wr_w = 1; s.rs1_e = 5; s.rs2_e = 5; step();
        check_eq("fwd_w_a", {30'b0, fwd_a_e}, 32'b01);
        check_eq("fwd_w_b", {30'b0, fwd_b_e}, 32'b01);
        s = '0; s.reg_wr_m = 1; s.reg_wr_w = 1; step();
        check_eq("fwd_x0", {28'b0, fwd_a_e, fwd_b_e}, 32'b0);
        s = '0; s.rd_m = 7; s.reg_wr_m = 1; s.rd_w = 7; s.reg_wr_w = 1; s.rs2_e = 7; step();
        check_eq("fwd_prio", {30'b0, fwd_b_e}, 32'b10);

        // load-use
        s = '0; s.res_src_e = 2'b01; s.reg_wr_e = 1; s.rd_e = 6; s.rs2_d = 6; step();
        check_eq("lu_ctl", {28'b0, stall_f, stall_d, flush_e, stall_e}, 32'b1110);
        s = '0; s.rd_w = 6; s.reg_wr_w = 1; s.rs2_e = 6; step();
        check_eq("lu_fwd", {30'b0, fwd_b_e}, 32'b01);
        check_eq("lu_cnt1", lu_stall_cnt, 32'd1);
        check_eq("lu_rel", {31'b0, stall_f}, 32'd0);

        // branch
        s = '0; s.pc_src_e = 1; step();
        check_eq("br_ctl", {29'b0, redirect, flush_d, flush_e}, 32'b111);
        s = '0; step();
        check_eq("br_cnt", flush_cnt, 32'd1);

        // memory freeze with pending branch
        s = '0; s.mem_req_m = 1; s.pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("frz_ctl", {24'b0, stall_f, stall_d, stall_e, stall_m, flush_w,
                                 redirect, flush_d, flush_e}, 32'b11111000);
            s.pc_src_e = 0;
        end
        s.mem_ready = 1; step();
        check_eq("frz_rel", {25'b0, stall_f, stall_d, stall_e, stall_m,
                             redirect, flush_d, flush_e}, 32'b0000111);
        check_eq("frz_mw", mem_wait_cnt, 32'd3);
        s = '0; step();
        check_eq("frz_fl", flush_cnt, 32'd2);
        check_eq("frz_rd", {31'b0, redirect}, 32'd0);

        // random traffic, biased to collide on a few registers
        for (int i = 0; i < 200; i++) begin
            s.rs1_d = 5'($urandom_range(0, 7)); s.rs2_d = 5'($urandom_range(0, 7));
            s.rs1_e = 5'($urandom_range(0, 7)); s.rs2_e = 5'($urandom_range(0, 7));
            s.rd_e = 5'($urandom_range(0, 7));  s.reg_wr_e = 1'($urandom_range(0, 1));
            s.res_src_e = 2'($urandom_range(0, 3));
            s.pc_src_e = ($urandom_range(0, 3) == 0);
            s.rd_m = 5'($urandom_range(0, 7));  s.reg_wr_m = 1'($urandom_range(0, 1));
            s.mem_req_m = ($urandom_range(0, 3) == 0);
            s.mem_ready = ($urandom_range(0, 3) != 0);
            s.rd_w = 5'($urandom_range(0, 7));  s.reg_wr_w = 1'($urandom_range(0, 1));
            step();
        end
        s = '0; step();

        // watchdog: 64 busy cycles then error, sticky
        s = '0; s.mem_req_m = 1; s.rd_m = 3; s.reg_wr_m = 1; s.rs1_e = 3;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            check_eq("wd_pre", {31'b0, mem_err}, 32'd0);
        end
        step();
        check_eq("wd_err", {27'b0, mem_err, stall_f, stall_d, stall_e, stall_m}, 32'b11111);
        s.mem_ready = 1; step();
        check_eq("wd_sticky", {31'b0, mem_err}, 32'd1);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_outs", {19'b0, obs}, {19'b0, 4'b0, 4'b0, 3'b111, 2'b00});
        check_eq("arst_lu", lu_stall_cnt, 32'd0);
        check_eq("arst_mw", mem_wait_cnt, 32'd0);
        check_eq("arst_fl", flush_cnt, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        s = '0; step();
        check_eq("post_rst", {31'b0, mem_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
